// File: rtl/timer_ctrl_master_if.sv
// -----------------------------------------------------------------------------
// timer_ctrl_master_if
// Avalon-MM link between timer_ctrl_master (initiator) and the 16-bit-data
// interval timer peripheral, plus the timer's interrupt line.
//
// Signals
//   av_address    [3:0]  timer register index          (master -> slave)
//   av_chipselect        Avalon chipselect             (master -> slave)
//   av_write_n           active-low write strobe       (master -> slave)
//   av_writedata  [15:0] write data                    (master -> slave)
//   av_readdata   [15:0] registered read data          (slave  -> master)
//   timer_irq            timer interrupt request       (slave  -> master)
// -----------------------------------------------------------------------------
interface timer_ctrl_master_if;
  logic [3:0]  av_address;
  logic        av_chipselect;
  logic        av_write_n;
  logic [15:0] av_writedata;
  logic [15:0] av_readdata;
  logic        timer_irq;

  modport master (
    output av_address,
    output av_chipselect,
    output av_write_n,
    output av_writedata,
    input  av_readdata,
    input  timer_irq
  );

  modport slave (
    input  av_address,
    input  av_chipselect,
    input  av_write_n,
    input  av_writedata,
    output av_readdata,
    output timer_irq
  );
endinterface

// File: rtl/timer_ctrl_master.sv
// -----------------------------------------------------------------------------
// timer_ctrl_master
// Hardware initiator that programs the interval timer (period + control), then
// services every timeout interrupt by clearing and reading back the status
// register, emitting one tick per serviced timeout. Used to generate game-frame
// ticks without processor involvement.
//
// Parameters
//   MIN_PERIOD  smallest accepted period_cycles; smaller starts are rejected
//   CNT_W       width of tick_count
//
// Ports
//   clk            system clock
//   reset          synchronous, active-high reset
//   start          pulse: program the timer and run continuously
//   stop           pulse: stop the timer
//   period_cycles  timer period in clk cycles, sampled on an accepted start
//   busy           high in every state except IDLE
//   tick           one-cycle pulse per serviced timeout
//   tick_count     serviced timeouts since the last accepted start (wraps)
//   overrun        sticky: TO still set after clearing; cleared on accepted start
//   cfg_err        one-cycle pulse: start rejected for a too-short period
//   av             Avalon-MM master port to the timer (see timer_ctrl_master_if)
// -----------------------------------------------------------------------------
module timer_ctrl_master #(
  parameter logic [31:0] MIN_PERIOD = 32'd8,
  parameter int          CNT_W      = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     stop,
  input  logic [31:0]              period_cycles,
  output logic                     busy,
  output logic                     tick,
  output logic [CNT_W-1:0]         tick_count,
  output logic                     overrun,
  output logic                     cfg_err,
  timer_ctrl_master_if.master      av
);

  // Timer register map (word index)
  localparam logic [3:0] REG_STATUS  = 4'd0;
  localparam logic [3:0] REG_CONTROL = 4'd1;
  localparam logic [3:0] REG_PERIODL = 4'd2;
  localparam logic [3:0] REG_PERIODH = 4'd3;
  localparam logic [3:0] REG_SNAPL   = 4'd4;
  localparam logic [3:0] REG_SNAPH   = 4'd5;

  // Control words: START|CONT|ITO to run, STOP with ITO=0 to halt.
  localparam logic [15:0] CTRL_RUN  = 16'h0007;
  localparam logic [15:0] CTRL_STOP = 16'h0008;
  localparam logic [15:0] STATUS_TO = 16'h0001;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_P0,
    S_WR_P1,
    S_WR_P2,
    S_WR_P3,
    S_WR_CTRL,
    S_RUN,
    S_CLR,
    S_RD_STAT,
    S_STOP
  } state_t;

  state_t      state_q, state_d;
  logic        rd_phase_q;   // 0: first read cycle, 1: readdata valid
  logic        stop_pend_q;
  logic [31:0] period_q;

  logic        start_ok;
  logic        start_bad;
  logic        stop_req;
  logic        tick_fire;
  logic [31:0] load_src;
  logic [31:0] load_val;

  logic [3:0]  addr_d;
  logic        cs_d;
  logic        write_n_d;
  logic [15:0] wdata_d;

  assign start_ok  = (state_q == S_IDLE) && start && (period_cycles >= MIN_PERIOD);
  assign start_bad = (state_q == S_IDLE) && start && (period_cycles <  MIN_PERIOD);
  // A stop arriving on the decision cycle itself counts as pending.
  assign stop_req  = stop_pend_q || stop;
  // Readdata is valid on the second cycle of the status read.
  assign tick_fire = (state_q == S_RD_STAT) && rd_phase_q;

  // The first period write is issued straight out of IDLE, before period_q
  // holds the new value, so the load value comes from the live input then.
  assign load_src = (state_q == S_IDLE) ? period_cycles : period_q;
  assign load_val = load_src - 32'd1;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rd_phase_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_phase_q <= (state_q == S_RD_STAT) && !rd_phase_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (start_ok) state_d = S_WR_P0;
      S_WR_P0:   state_d = S_WR_P1;
      S_WR_P1:   state_d = S_WR_P2;
      S_WR_P2:   state_d = S_WR_P3;
      S_WR_P3:   state_d = S_WR_CTRL;
      S_WR_CTRL: state_d = stop_req ? S_STOP : S_RUN;
      S_RUN: begin
        // stop has priority over a simultaneous interrupt
        if (stop)               state_d = S_STOP;
        else if (av.timer_irq)  state_d = S_CLR;
      end
      S_CLR:     state_d = S_RD_STAT;
      S_RD_STAT: if (rd_phase_q) state_d = stop_req ? S_STOP : S_RUN;
      S_STOP:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: bus values for the state being entered, registered below so
  // the bus cycle appears in the first clock of that state.
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned here gets a default first, so no path through
  // the case can leave a value unassigned and infer a latch.
  always_comb begin
    addr_d    = 4'd0;
    cs_d      = 1'b0;
    write_n_d = 1'b1;
    wdata_d   = 16'h0000;
    unique case (state_d)
      S_WR_P0: begin
        cs_d = 1'b1; write_n_d = 1'b0; addr_d = REG_PERIODL; wdata_d = load_val[15:0];
      end
      S_WR_P1: begin
        cs_d = 1'b1; write_n_d = 1'b0; addr_d = REG_PERIODH; wdata_d = load_val[31:16];
      end
      S_WR_P2: begin
        cs_d = 1'b1; write_n_d = 1'b0; addr_d = REG_SNAPL;
      end
      S_WR_P3: begin
        cs_d = 1'b1; write_n_d = 1'b0; addr_d = REG_SNAPH;
      end
      S_WR_CTRL: begin
        cs_d = 1'b1; write_n_d = 1'b0; addr_d = REG_CONTROL; wdata_d = CTRL_RUN;
      end
      S_CLR: begin
        cs_d = 1'b1; write_n_d = 1'b0; addr_d = REG_STATUS;
      end
      S_RD_STAT: begin
        cs_d = 1'b1; addr_d = REG_STATUS;
      end
      S_STOP: begin
        cs_d = 1'b1; write_n_d = 1'b0; addr_d = REG_CONTROL; wdata_d = CTRL_STOP;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered outputs, tick counter, sticky flags, stop latch
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      busy             <= 1'b0;
      tick             <= 1'b0;
      tick_count       <= '0;
      overrun          <= 1'b0;
      cfg_err          <= 1'b0;
      av.av_address    <= 4'd0;
      av.av_chipselect <= 1'b0;
      av.av_write_n    <= 1'b1;
      av.av_writedata  <= 16'h0000;
      stop_pend_q      <= 1'b0;
      period_q         <= 32'd0;
    end else begin
      busy             <= (state_d != S_IDLE);
      tick             <= tick_fire;
      cfg_err          <= start_bad;
      av.av_address    <= addr_d;
      av.av_chipselect <= cs_d;
      av.av_write_n    <= write_n_d;
      av.av_writedata  <= wdata_d;

      if (start_ok) begin
        period_q   <= period_cycles;
        tick_count <= '0;
        overrun    <= 1'b0;
      end else if (tick_fire) begin
        tick_count <= tick_count + CNT_ONE;
        // TO still set right after clearing it means a timeout was missed.
        if ((av.av_readdata & STATUS_TO) != 16'h0000) overrun <= 1'b1;
      end

      // Stops are only latched where they cannot act immediately; RUN acts
      // directly and IDLE/STOP ignore them.
      if (state_d == S_STOP) begin
        stop_pend_q <= 1'b0;
      end else if (stop && (state_q != S_IDLE) && (state_q != S_RUN) &&
                   (state_q != S_STOP)) begin
        stop_pend_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_timer_ctrl_master.sv
// -----------------------------------------------------------------------------
// tb_timer_ctrl_master
// Bench for timer_ctrl_master: a behavioural interval-timer peripheral, a
// plan-queue reference model of the expected bus traffic and flags, a
// per-cycle compare process, and directed scenarios with literal expectations.
// -----------------------------------------------------------------------------
module tb_timer_ctrl_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [31:0] period_cycles = 32'd0;
  logic        busy, tick, overrun, cfg_err;
  logic [15:0] tick_count;

  timer_ctrl_master_if bus ();

  timer_ctrl_master #(.MIN_PERIOD(32'd8), .CNT_W(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .stop          (stop),
    .period_cycles (period_cycles),
    .busy          (busy),
    .tick          (tick),
    .tick_count    (tick_count),
    .overrun       (overrun),
    .cfg_err       (cfg_err),
    .av            (bus.master)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural interval timer (16-bit data variant)
  // ---------------------------------------------------------------------------
  logic [15:0] t_pl, t_ph, t_rd;
  logic [3:0]  t_ctrl;
  logic        t_to, t_run;
  logic [31:0] t_cnt;
  logic        force_stuck = 1'b0;  // status read returns TO=1 regardless
  logic        irq_force = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      t_pl <= 16'h0; t_ph <= 16'h0; t_rd <= 16'h0; t_ctrl <= 4'h0;
      t_to <= 1'b0; t_run <= 1'b0; t_cnt <= 32'd0;
    end else begin
      if (bus.av_chipselect && bus.av_write_n) begin
        case (bus.av_address)
          4'd0:    t_rd <= {14'b0, t_run, t_to | force_stuck};
          4'd1:    t_rd <= {12'b0, t_ctrl};
          4'd2:    t_rd <= t_pl;
          4'd3:    t_rd <= t_ph;
          default: t_rd <= 16'h0;
        endcase
      end
      if (bus.av_chipselect && !bus.av_write_n) begin
        case (bus.av_address)
          4'd0: t_to <= 1'b0;
          4'd1: begin
            t_ctrl <= bus.av_writedata[3:0];
            if (bus.av_writedata[2]) begin t_cnt <= {t_ph, t_pl}; t_run <= 1'b1; end
            if (bus.av_writedata[3]) t_run <= 1'b0;
          end
          4'd2: t_pl <= bus.av_writedata;
          4'd3: t_ph <= bus.av_writedata;
          default: ;
        endcase
      end
      if (t_run) begin
        if (t_cnt == 32'd0) begin
          t_to <= 1'b1;
          if (t_ctrl[1]) t_cnt <= {t_ph, t_pl};
          else           t_run <= 1'b0;
        end else begin
          t_cnt <= t_cnt - 32'd1;
        end
      end
    end
  end

  assign bus.av_readdata = t_rd;
  assign bus.timer_irq   = (t_to & t_ctrl[0]) | irq_force;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // ---------------------------------------------------------------------------
  // Reference model: a queue of planned bus cycles, one entry per clock.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic        wn;
    logic [3:0]  addr;
    logic [15:0] data;
    logic        is_rd2;   // second read cycle: status sampled, tick follows
    logic        decide;   // run-entry decision point after this cycle
    logic        last_op;  // stop write: idle afterwards
  } op_t;

  op_t         plan[$];
  logic [15:0] rb_log[$];
  logic        m_valid = 1'b0;
  logic        m_active, m_pend, m_over;
  logic [15:0] m_count;
  logic        exp_busy, exp_tick, exp_cfg, exp_cs, exp_wn;
  logic [3:0]  exp_addr;
  logic [15:0] exp_data;

  function automatic op_t wr(input logic [3:0] a, input logic [15:0] d,
                             input logic dec, input logic lst);
    op_t o;
    o = '{wn: 1'b0, addr: a, data: d, is_rd2: 1'b0, decide: dec, last_op: lst};
    return o;
  endfunction

  function automatic op_t rd(input logic second);
    op_t o;
    o = '{wn: 1'b1, addr: 4'd0, data: 16'h0, is_rd2: second, decide: second, last_op: 1'b0};
    return o;
  endfunction

  task automatic model_step();
    op_t         op;
    logic [31:0] l;
    exp_tick = 1'b0;
    exp_cfg  = 1'b0;
    if (reset) begin
      plan.delete();
      m_active = 1'b0; m_pend = 1'b0; m_over = 1'b0; m_count = 16'd0;
      m_valid  = 1'b1;
    end else if (plan.size() == 0) begin
      if (!m_active) begin
        if (start) begin
          if (period_cycles >= 32'd8) begin
            l = period_cycles - 32'd1;
            m_active = 1'b1; m_count = 16'd0; m_over = 1'b0;
            plan.push_back(wr(4'd2, l[15:0], 1'b0, 1'b0));
            plan.push_back(wr(4'd3, l[31:16], 1'b0, 1'b0));
            plan.push_back(wr(4'd4, 16'h0, 1'b0, 1'b0));
            plan.push_back(wr(4'd5, 16'h0, 1'b0, 1'b0));
            plan.push_back(wr(4'd1, 16'h0007, 1'b1, 1'b0));
          end else begin
            exp_cfg = 1'b1;
          end
        end
      end else if (stop) begin
        plan.push_back(wr(4'd1, 16'h0008, 1'b0, 1'b1));
      end else if (bus.timer_irq) begin
        plan.push_back(wr(4'd0, 16'h0, 1'b0, 1'b0));
        plan.push_back(rd(1'b0));
        plan.push_back(rd(1'b1));
      end
    end else begin
      op = plan.pop_front();
      if (stop && !op.last_op) m_pend = 1'b1;
      if (op.is_rd2) begin
        rb_log.push_back(bus.av_readdata);
        if (bus.av_readdata[0]) m_over = 1'b1;
        m_count  = m_count + 16'd1;
        exp_tick = 1'b1;
      end
      if (op.decide && m_pend) begin
        m_pend = 1'b0;
        plan.push_back(wr(4'd1, 16'h0008, 1'b0, 1'b1));
      end
      if (op.last_op) m_active = 1'b0;
    end
    exp_busy = m_active;
    if (plan.size() != 0) begin
      exp_cs = 1'b1; exp_wn = plan[0].wn; exp_addr = plan[0].addr; exp_data = plan[0].data;
    end else begin
      exp_cs = 1'b0; exp_wn = 1'b1; exp_addr = 4'd0; exp_data = 16'h0;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle comparison of every output against the model.
  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      check("cycle_outputs",
            {22'b0, busy, tick, tick_count, overrun, cfg_err,
             bus.av_chipselect, bus.av_write_n, bus.av_address, bus.av_writedata},
            {22'b0, exp_busy, exp_tick, m_count, m_over, exp_cfg,
             exp_cs, exp_wn, exp_addr, exp_data});
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus helpers (inputs change on the falling edge)
  // ---------------------------------------------------------------------------
  int tick_times[$];

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b0; stop = 1'b0; irq_force = 1'b0; force_stuck = 1'b0;
    cyc(2);
    reset = 1'b0;
  endtask

  task automatic pulse_start(input logic [31:0] p);
    period_cycles = p;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic check_bus(input string name, input logic cs, input logic wn,
                           input logic [3:0] a, input logic [15:0] d);
    check(name, {42'b0, bus.av_chipselect, bus.av_write_n, bus.av_address, bus.av_writedata},
                {42'b0, cs, wn, a, d});
  endtask

  task automatic wait_ticks(input string name, input int n, input int budget);
    int seen = 0;
    int k = 0;
    while (seen < n && k < budget) begin
      @(negedge clk);
      k++;
      if (tick === 1'b1) begin
        seen++;
        tick_times.push_back(cyc_n);
      end
    end
    if (seen < n) check(name, seen, n);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k = 0;
    while (busy !== 1'b0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, busy, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cs_seen;
    int ticks_seen;

    // 1) reset values, then programming sequence for period 50000 (L = 0xC34F)
    do_reset();
    check("reset_busy", busy, 1'b0);
    check("reset_flags", {tick, overrun, cfg_err, tick_count}, 19'h0);
    check_bus("reset_bus", 1'b0, 1'b1, 4'd0, 16'h0);
    pulse_start(32'd50000);
    check("t1_busy_cycle1", busy, 1'b1);
    check_bus("t1_wr_p0", 1'b1, 1'b0, 4'd2, 16'hC34F);
    cyc(1); check_bus("t1_wr_p1", 1'b1, 1'b0, 4'd3, 16'h0000);
    cyc(1); check_bus("t1_wr_p2", 1'b1, 1'b0, 4'd4, 16'h0000);
    cyc(1); check_bus("t1_wr_p3", 1'b1, 1'b0, 4'd5, 16'h0000);
    cyc(1); check_bus("t1_wr_ctrl", 1'b1, 1'b0, 4'd1, 16'h0007);
    cyc(1); check_bus("t1_run_idle_bus", 1'b0, 1'b1, 4'd0, 16'h0000);

    // 2) rejected start (7) and smallest accepted start (8)
    do_reset();
    pulse_start(32'd7);
    check("t3_cfg_err", cfg_err, 1'b1);
    check("t3_busy", busy, 1'b0);
    check("t3_no_bus", bus.av_chipselect, 1'b0);
    cyc(1);
    check("t3_cfg_err_pulse", cfg_err, 1'b0);
    check("t3_still_idle", {busy, bus.av_chipselect}, 2'b00);
    pulse_start(32'd8);
    check("t3_min_accepted", busy, 1'b1);
    check_bus("t3_min_load", 1'b1, 1'b0, 4'd2, 16'h0007);

    // 3) continuous run with the real timer, period 100
    do_reset();
    tick_times.delete();
    rb_log.delete();
    pulse_start(32'd100);
    wait_ticks("t2_five_ticks", 5, 1000);
    check("t2_tick_count", tick_count, 16'd5);
    check("t2_overrun", overrun, 1'b0);
    if (tick_times.size() == 5)
      for (int i = 1; i < 5; i++) check("t2_interval", tick_times[i] - tick_times[i-1], 100);
    check("t2_readbacks", rb_log.size(), 5);
    foreach (rb_log[i]) check("t2_status", rb_log[i], 16'h0002);
    pulse_stop();
    wait_idle("t2_stop_idle", 20);

    // 4) stop during WR_P2: config completes, then the stop write, then idle
    do_reset();
    pulse_start(32'd20);
    cyc(2);
    check_bus("t4_wr_p2", 1'b1, 1'b0, 4'd4, 16'h0000);
    pulse_stop();
    check_bus("t4_wr_p3", 1'b1, 1'b0, 4'd5, 16'h0000);
    cyc(1); check_bus("t4_wr_ctrl", 1'b1, 1'b0, 4'd1, 16'h0007);
    cyc(1); check_bus("t4_stop_wr", 1'b1, 1'b0, 4'd1, 16'h0008);
    check("t4_busy_in_stop", busy, 1'b1);
    cyc(1);
    check("t4_idle", {busy, bus.av_chipselect}, 2'b00);
    cs_seen = 0; ticks_seen = 0;
    repeat (200) begin
      @(negedge clk);
      if (bus.av_chipselect) cs_seen++;
      if (tick) ticks_seen++;
    end
    check("t4_no_bus_after_stop", cs_seen, 0);
    check("t4_no_tick_after_stop", ticks_seen, 0);

    // 5) stuck TO bit on readback -> sticky overrun until next accepted start
    do_reset();
    rb_log.delete();
    force_stuck = 1'b1;
    pulse_start(32'd100);
    wait_ticks("t5_tick1", 1, 500);
    check("t5_overrun_set", overrun, 1'b1);
    check("t5_status_0003", rb_log.size() > 0 ? rb_log[$] : 16'hxxxx, 16'h0003);
    wait_ticks("t5_tick2", 1, 500);
    check("t5_overrun_sticky", overrun, 1'b1);
    check("t5_count2", tick_count, 16'd2);
    force_stuck = 1'b0;
    pulse_stop();
    wait_idle("t5_stop_idle", 20);
    check("t5_overrun_after_stop", overrun, 1'b1);
    pulse_start(32'd100);
    check("t5_overrun_cleared", overrun, 1'b0);
    check("t5_count_cleared", tick_count, 16'd0);

    // 6) stop and irq together in RUN -> stop write, no tick
    do_reset();
    pulse_start(32'd100);
    cyc(6);
    irq_force = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    irq_force = 1'b0;
    stop = 1'b0;
    check_bus("t6_stop_wins", 1'b1, 1'b0, 4'd1, 16'h0008);
    ticks_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (tick) ticks_seen++;
    end
    check("t6_no_tick", ticks_seen, 0);
    check("t6_idle", {busy, tick_count}, 17'h0);

    // 7) reset asserted while in CLR -> all outputs at reset values next cycle
    do_reset();
    pulse_start(32'd100);
    cyc(6);
    irq_force = 1'b1;
    @(negedge clk);
    irq_force = 1'b0;
    check_bus("t7_clr_write", 1'b1, 1'b0, 4'd0, 16'h0000);
    reset = 1'b1;
    @(negedge clk);
    check("t7_reset_flags", {busy, tick, overrun, cfg_err, tick_count}, 20'h0);
    check_bus("t7_reset_bus", 1'b0, 1'b1, 4'd0, 16'h0000);
    reset = 1'b0;
    cyc(3);
    check("t7_stays_idle", {busy, bus.av_chipselect}, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
